// File: rtl/ctrl_ramdrv_addrgen.sv
// Sample-RAM address generator: one-shot write at the vector head, or a full
// descending ring sweep from the head. Optional ram_ready stalls: ADDRGEN_STALL_EN.
module ctrl_ramdrv_addrgen #(
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int VECTOR_INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH         = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          wr_mode,
  input  logic [VECTOR_INDEX_WIDTH-1:0] index,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [DATA_OFFSET_WIDTH-1:0]  length,
  input  logic [DATA_OFFSET_WIDTH-1:0]  head_offset,
  input  logic                          ram_ready,
  output logic                          head_read,
  output logic                          head_inc,
  output logic [VECTOR_INDEX_WIDTH-1:0] head_index,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_valid,
  output logic                          ram_we,
  output logic                          busy,
  output logic                          done
);

  localparam int DW    = DATA_OFFSET_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int SUM_W = (AW > DW) ? AW : DW;

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, INC, READ, DONE} state_t;

  state_t        state;
  logic          wr_r;
  logic [AW-1:0] base_r;
  logic [DW-1:0] len_r;
  logic [DW-1:0] offset;
  logic [DW-1:0] remain;
  logic [DW-1:0] next_off;
  logic          ready;

`ifdef ADDRGEN_STALL_EN
  assign ready = ram_ready;
`else
  // ram_ready is folded away so the port stays connected but has no effect
  assign ready = ram_ready | 1'b1;
`endif

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [DW-1:0] o);
    logic [SUM_W-1:0] s;
    s = SUM_W'(b) + SUM_W'(o);
    return s[AW-1:0];
  endfunction

  always_comb begin
    next_off = (offset == '0) ? len_r : offset - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_r       <= 1'b0;
      base_r     <= '0;
      len_r      <= '0;
      offset     <= '0;
      remain     <= '0;
      head_read  <= 1'b0;
      head_inc   <= 1'b0;
      head_index <= '0;
      ram_addr   <= '0;
      ram_valid  <= 1'b0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      head_read <= 1'b0;
      head_inc  <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            wr_r       <= wr_mode;
            head_index <= index;
            base_r     <= base_addr;
            len_r      <= length;
            head_read  <= 1'b1;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          offset    <= head_offset;
          remain    <= len_r;
          ram_addr  <= addr_of(base_r, head_offset);
          ram_valid <= 1'b1;
          ram_we    <= wr_r;
          state     <= wr_r ? WRITE : READ;
        end
        WRITE: begin
          if (ready) begin
            ram_valid <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            head_inc  <= 1'b1;
            state     <= INC;
          end
        end
        INC: begin
          done  <= 1'b1;
          state <= DONE;
        end
        READ: begin
          // remain counts addresses still to emit after the one on the bus
          if (ready) begin
            if (remain == '0) begin
              ram_valid <= 1'b0;
              ram_addr  <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              offset   <= next_off;
              remain   <= remain - DW'(1);
              ram_addr <= addr_of(base_r, next_off);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_ramdrv_addrgen.sv
// Randomized bench for ctrl_ramdrv_addrgen against a job-level reference model
// with a small header-block model supplying head offsets.
module tb_ctrl_ramdrv_addrgen;
  localparam int DW = 10;
  localparam int VW = 4;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          wr_mode = 1'b0;
  logic [VW-1:0] index = '0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] length = '0;
  logic [DW-1:0] head_offset = '0;
  logic          ram_ready = 1'b1;
  logic          head_read, head_inc, ram_valid, ram_we, busy, done;
  logic [VW-1:0] head_index;
  logic [AW-1:0] ram_addr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] hdr [16];

  ctrl_ramdrv_addrgen #(
    .DATA_OFFSET_WIDTH (DW),
    .VECTOR_INDEX_WIDTH(VW),
    .ADDR_WIDTH        (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wr_mode    (wr_mode),
    .index      (index),
    .base_addr  (base_addr),
    .length     (length),
    .head_offset(head_offset),
    .ram_ready  (ram_ready),
    .head_read  (head_read),
    .head_inc   (head_inc),
    .head_index (head_index),
    .ram_addr   (ram_addr),
    .ram_valid  (ram_valid),
    .ram_we     (ram_we),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge and act as the header block.
  task automatic cycle();
    @(negedge clk);
    if (head_inc) hdr[head_index] = hdr[head_index] + DW'(1);
    head_offset = head_read ? hdr[head_index] : DW'($urandom);
  endtask

  // Noise on the job inputs while busy; the DUT must ignore all of it.
  task automatic scramble();
    start     = ($urandom_range(3) == 0);
    wr_mode   = 1'($urandom);
    index     = VW'($urandom);
    base_addr = AW'($urandom);
    length    = DW'($urandom);
  endtask

  task automatic run_job(input bit wr, input logic [VW-1:0] idx, input logic [AW-1:0] base,
                         input logic [DW-1:0] len, input int stall_at, input int stall_n,
                         input bit rnd);
    logic [DW-1:0] h;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] exp_a;
    int            off;
    int            held;
    int            k;
    bit            eff;
    h = hdr[idx];
    if (wr) exp_q.push_back(base + AW'(h));
    else begin
      for (int i = 0; i <= int'(len); i++) begin
        off = (i <= int'(h)) ? int'(h) - i : int'(len) - (i - int'(h) - 1);
        exp_q.push_back(base + AW'(off));
      end
    end
    wr_mode = wr; index = idx; base_addr = base; length = len; start = 1'b1;
    cycle();
    chk("fetch_head_read", head_read, 1);
    chk("fetch_head_index", head_index, idx);
    chk("fetch_busy", busy, 1);
    chk("fetch_ram_valid", ram_valid, 0);
    chk("fetch_head_inc", head_inc, 0);
    scramble();
    ram_ready = 1'($urandom);
    cycle();
    k = 0;
    while (exp_q.size() > 0) begin
      exp_a = exp_q[0];
      held = 0;
      eff = 1'b0;
      while (!eff) begin
        chk("addr_valid", ram_valid, 1);
        chk("addr_value", ram_addr, exp_a);
        chk("addr_we", ram_we, wr);
        chk("addr_strobes", {head_read, head_inc, done}, 0);
        chk("addr_busy", busy, 1);
        if (k == stall_at && held < stall_n) ram_ready = 1'b0;
        else ram_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
`ifdef ADDRGEN_STALL_EN
        eff = ram_ready;
`else
        eff = 1'b1;
`endif
        held++;
        if (held > 100) begin
          chk("stall_bound", 0, 1);
          return;
        end
        scramble();
        cycle();
      end
      void'(exp_q.pop_front());
      k++;
    end
    if (wr) begin
      chk("inc_head_inc", head_inc, 1);
      chk("inc_head_read", head_read, 0);
      chk("inc_head_index", head_index, idx);
      chk("inc_ram_valid", ram_valid, 0);
      chk("inc_done", done, 0);
      scramble();
      cycle();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_strobes", {head_read, head_inc, ram_valid}, 0);
    scramble();
    cycle();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ram_valid", ram_valid, 0);
    cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {head_read, head_inc, head_index, ram_addr, ram_valid, ram_we, busy, done}, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hdr[i] = DW'($urandom_range(30));
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset_outputs");
    cycle();
    cycle();
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    cycle();

    hdr[3] = 5;
    run_job(1'b1, 4'd3, 14'h100, 10'd7, -1, 0, 1'b0);
    chk("write_head_advanced", hdr[3], 6);

    hdr[7] = 1;
    run_job(1'b0, 4'd7, 14'h200, 10'd3, -1, 0, 1'b0);
    run_job(1'b0, 4'd7, 14'h200, 10'd3, 1, 2, 1'b0);

    hdr[9] = 3;
    run_job(1'b1, 4'd9, 14'h3FFE, 10'd0, -1, 0, 1'b0);

    hdr[4] = 12;
    run_job(1'b0, 4'd4, 14'h040, 10'd0, -1, 0, 1'b0);
    hdr[5] = 9;
    run_job(1'b0, 4'd5, 14'h080, 10'd3, -1, 0, 1'b1);

    // Reset in the middle of a read sweep, after two addresses.
    hdr[2] = 4;
    wr_mode = 1'b0; index = 4'd2; base_addr = 14'h050; length = 10'd6; start = 1'b1;
    ram_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    chk("abort_second_addr", ram_addr, 14'h053);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort_async_zero");
    cycle();
    chk_all_zero("abort_held_zero");
    rst_n = 1'b1;
    cycle();
    chk_all_zero("abort_after_release");
    chk("abort_no_head_inc", hdr[2], 4);
    run_job(1'b0, 4'd2, 14'h050, 10'd6, -1, 0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      run_job(1'($urandom), VW'($urandom), AW'($urandom), DW'($urandom_range(12)),
              -1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_ramdrv_addrgen.md
CTRL_RAMDRV_ADDRGEN -- requirements
Module: ctrl_ramdrv_addrgen

Interface
REQ-001 SHALL have parameter DATA_OFFSET_WIDTH, default 10, meaning width of per-vector head offset and length.
REQ-002 SHALL have parameter VECTOR_INDEX_WIDTH, default 4, meaning width of vector index.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning width of sample RAM address.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  in  1  one-cycle job request, sampled only in IDLE.
REQ-007 SHALL have port wr_mode  in  1  captured with start: 1 = write new sample, 0 = read sweep.
REQ-008 SHALL have port index  in  VECTOR_INDEX_WIDTH  vector index, captured with start.
REQ-009 SHALL have port base_addr  in  ADDR_WIDTH  RAM base of vector, captured with start.
REQ-010 SHALL have port length  in  DATA_OFFSET_WIDTH  last valid offset (buffer holds length+1 entries), captured with start.
REQ-011 SHALL have port head_offset  in  DATA_OFFSET_WIDTH  head offset from header block, valid only while head_read=1.
REQ-012 SHALL have port ram_ready  in  1  RAM accepts current address.
REQ-013 SHALL have port head_read  out  1  read_reg strobe to header block.
REQ-014 SHALL have port head_inc  out  1  head_inc strobe to header block.
REQ-015 SHALL have port head_index  out  VECTOR_INDEX_WIDTH  captured index to header block.
REQ-016 SHALL have port ram_addr  out  ADDR_WIDTH  RAM address.
REQ-017 SHALL have port ram_valid  out  1  ram_addr valid this cycle.
REQ-018 SHALL have port ram_we  out  1  write enable, only with ram_valid in write job.
REQ-019 SHALL have ports busy, done  out  1 each  busy = not IDLE; done = one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, FETCH, WRITE, INC, READ, DONE.
REQ-021 IDLE: start=1 captures wr_mode/index/base_addr/length, goes FETCH; start ignored in every other state.
REQ-022 FETCH (exactly one cycle): head_read=1, head_index=captured index; head_offset registered at end of cycle; next WRITE if wr_mode else READ.
REQ-023 WRITE: ram_addr = base + head, ram_valid=1, ram_we=1; held until ram_ready=1 sampled, then INC.
REQ-024 INC (exactly one cycle): head_inc=1, head_read=0; next DONE.
REQ-025 READ: emits length+1 addresses, offset starting at head, decrementing; offset 0 followed by offset=length (wrap); ram_we=0.
REQ-026 READ: address/offset advance only on cycle with ram_valid=1 and ram_ready=1; last accepted address goes DONE.
REQ-027 DONE (one cycle): done=1, busy=0 is NOT asserted until IDLE; next IDLE.
REQ-028 Address arithmetic: ram_addr = base_addr + zero-extended offset, truncated modulo 2^ADDR_WIDTH.
REQ-029 head_read and head_inc SHALL never be high in the same cycle; both 0 outside FETCH/INC.
REQ-030 length=0: READ emits one address (base+head); head_offset > length: sweep still emits length+1 addresses, first from head, wrap at 0 to length.
REQ-031 Latency with ram_ready=1: start at edge N -> FETCH cycle N+1 -> first address cycle N+2; read job done at N+3+length; write job done at N+4.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and all outputs 0 (ram_addr=0, head_index=0), including mid-job; no head_inc issued for an aborted job.
REQ-033 Captured registers SHALL reset to 0; first start after rst_n release SHALL be honoured.

Configuration
REQ-034 Macro ADDRGEN_STALL_EN defined: ram_ready honoured per REQ-023/026.
REQ-035 Macro ADDRGEN_STALL_EN undefined: ram_ready ignored, treated as constant 1; port remains present.

Verification
REQ-036 Write job: base=0x100, index=3, head=5, ram_ready=1 -> one cycle ram_addr=0x105, ram_we=1, then head_inc=1 with head_index=3, done next cycle.
REQ-037 Read job: base=0x200, length=3, head=1 -> addresses 0x201, 0x200, 0x203, 0x202 on consecutive cycles, ram_we=0, then done.
REQ-038 Stall (ADDRGEN_STALL_EN): same read, ram_ready=0 for 2 cycles on 2nd address -> 0x200 held 3 cycles, sequence otherwise unchanged.
REQ-039 Wrap: base=0x3FFE (ADDR_WIDTH=14), head=3, write -> ram_addr=0x0001.
REQ-040 Reset mid-READ after 2 addresses -> outputs 0 asynchronously, no done, no head_inc; next start runs full job.
REQ-041 start pulsed while busy -> ignored; length=0 read -> single address base+head, then done.
